// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and FSM encoding for the register scoreboard.
package reg_scoreboard_pkg;
  localparam int NREG    = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter.
// Increments stop at the maximum count; decrements stop at zero.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int CW = reg_scoreboard_pkg::CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic zero,
  output logic full
);
  localparam logic [CW-1:0] MAXV = '1;

  logic [CW-1:0] cnt;

  assign zero = (cnt == '0);
  assign full = (cnt == MAXV);

  // An increment and a decrement in the same cycle cancel out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per register.
// It blocks the issue of RAW hazards and of destinations whose counter is saturated.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG  = reg_scoreboard_pkg::NREG,
  parameter int CNT_W = reg_scoreboard_pkg::CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_uses_rs1,
  input  logic              issue_uses_rs2,
  input  logic              issue_writes_rd,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic              flush,
  output logic [NREG-1:0]   busy_vector,
  output logic [6:0]        outstanding,
  output logic [15:0]       stall_count,
  output logic              underflow_err
);
  state_t state;

  logic [NREG-1:0] zero;
  logic [NREG-1:0] full;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;

  logic run;
  logic rs1_hit;
  logic rs2_hit;
  logic rd_full;
  logic fire;
  logic inc_en;
  logic wb_en;
  logic any_dec;
  logic underflow_hit;

  // x0 is never tracked: it always reads as idle.
  assign zero[0] = 1'b1;
  assign full[0] = 1'b0;
  assign inc[0]  = 1'b0;
  assign dec[0]  = 1'b0;

  assign run = (state == RUN);

  assign rs1_hit = issue_uses_rs1 && (issue_rs1 != '0)
                && !zero[issue_rs1];
  assign rs2_hit = issue_uses_rs2 && (issue_rs2 != '0)
                && !zero[issue_rs2];
  assign rd_full = issue_writes_rd && (issue_rd != '0)
                && full[issue_rd];

  assign issue_ready = run && !rs1_hit && !rs2_hit && !rd_full;

  assign fire   = issue_valid && issue_ready && !flush;
  assign inc_en = fire && issue_writes_rd && (issue_rd != '0);
  assign wb_en  = wb_valid && (wb_rd != '0) && run && !flush;

  assign underflow_hit = wb_en && zero[wb_rd];
  assign any_dec       = |dec;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    assign inc[i] = inc_en && (issue_rd == ADDR_W'(i));
    assign dec[i] = wb_en && (wb_rd == ADDR_W'(i)) && !zero[i];

    sb_counter #(
      .CW (CNT_W)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .clr   (flush),
      .zero  (zero[i]),
      .full  (full[i])
    );
  end

  assign busy_vector = ~zero;

  // At most one increment and one decrement land per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      outstanding   <= '0;
      stall_count   <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (flush) begin
        state       <= FLUSH;
        outstanding <= '0;
      end else if (state == FLUSH) begin
        state       <= RUN;
      end else begin
        outstanding <= outstanding + 7'(inc_en) - 7'(any_dec);
      end
      if (issue_valid && !issue_ready
          && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
      if (underflow_hit) begin
        underflow_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a random run.
// Expected values come from an array-of-counts reference model.
module tb_reg_scoreboard;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0;
  logic [4:0]  issue_rs2 = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_uses_rs1 = 1'b0;
  logic        issue_uses_rs2 = 1'b0;
  logic        issue_writes_rd = 1'b0;
  logic        issue_ready;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] busy_vector;
  logic [6:0]  outstanding;
  logic [15:0] stall_count;
  logic        underflow_err;

  always #5 clock = ~clock;

  reg_scoreboard dut (
    .clock           (clock),
    .reset           (reset),
    .issue_valid     (issue_valid),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_rd        (issue_rd),
    .issue_uses_rs1  (issue_uses_rs1),
    .issue_uses_rs2  (issue_uses_rs2),
    .issue_writes_rd (issue_writes_rd),
    .issue_ready     (issue_ready),
    .wb_valid        (wb_valid),
    .wb_rd           (wb_rd),
    .flush           (flush),
    .busy_vector     (busy_vector),
    .outstanding     (outstanding),
    .stall_count     (stall_count),
    .underflow_err   (underflow_err)
  );

  int m_cnt[32];
  bit m_flush;
  bit m_err;
  int m_stall;
  int nvec;
  int nerr;
  bit obs_ready;
  bit exp_ready;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_flush = 0;
    m_err   = 0;
    m_stall = 0;
  endfunction

  function automatic bit model_ready();
    if (m_flush) return 0;
    if (issue_uses_rs1 && issue_rs1 != 0 && m_cnt[issue_rs1] > 0)
      return 0;
    if (issue_uses_rs2 && issue_rs2 != 0 && m_cnt[issue_rs2] > 0)
      return 0;
    if (issue_writes_rd && issue_rd != 0 && m_cnt[issue_rd] == 3)
      return 0;
    return 1;
  endfunction

  function automatic int model_sum();
    int s = 0;
    for (int i = 0; i < 32; i++) s += m_cnt[i];
    return s;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
    return b;
  endfunction

  task automatic set_issue(input bit v, input bit u1, input int r1,
                           input bit u2, input int r2,
                           input bit w, input int d);
    issue_valid     = v;
    issue_uses_rs1  = u1;
    issue_rs1       = 5'(r1);
    issue_uses_rs2  = u2;
    issue_rs2       = 5'(r2);
    issue_writes_rd = w;
    issue_rd        = 5'(d);
  endtask

  task automatic set_wb(input bit v, input int d);
    wb_valid = v;
    wb_rd    = 5'(d);
  endtask

  task automatic idle();
    set_issue(0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0);
    flush = 0;
  endtask

  // One clock: sample readiness mid-cycle, advance the model at the edge.
  task automatic step();
    int nc[32];
    @(negedge clock);
    obs_ready = issue_ready;
    exp_ready = model_ready();
    @(posedge clock);
    if (issue_valid && !exp_ready && m_stall < 65535) m_stall++;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      m_flush = 1;
    end else if (m_flush) begin
      m_flush = 0;
    end else begin
      nc = m_cnt;
      if (wb_valid && wb_rd != 0) begin
        if (m_cnt[wb_rd] == 0) m_err = 1;
        else nc[wb_rd] = nc[wb_rd] - 1;
      end
      if (issue_valid && exp_ready && issue_writes_rd && issue_rd != 0)
        nc[issue_rd] = nc[issue_rd] + 1;
      m_cnt = nc;
    end
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    nvec++;
    if (busy_vector !== '0) begin
      nerr++;
      $display("FAIL rst_busy got=%h exp=0", busy_vector);
    end
    nvec++;
    if (outstanding !== '0 || stall_count !== '0) begin
      nerr++;
      $display("FAIL rst_cnt got out=%0d stall=%0d exp=0",
               outstanding, stall_count);
    end
    nvec++;
    if (underflow_err !== 1'b0) begin
      nerr++;
      $display("FAIL rst_err got=%b exp=0", underflow_err);
    end
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_raw_stall();
    set_issue(1, 0, 0, 0, 0, 1, 5);
    step();
    nvec++;
    if (obs_ready !== 1'b1 || busy_vector[5] !== 1'b1) begin
      nerr++;
      $display("FAIL raw_issue got rdy=%b busy5=%b exp 1 1",
               obs_ready, busy_vector[5]);
    end
    set_issue(1, 1, 5, 0, 0, 0, 0);
    step();
    nvec++;
    if (obs_ready !== 1'b0 || stall_count !== 16'd1) begin
      nerr++;
      $display("FAIL raw_stall got rdy=%b stall=%0d exp 0 1",
               obs_ready, stall_count);
    end
    set_wb(1, 5);
    step();
    nvec++;
    if (obs_ready !== 1'b0 || busy_vector[5] !== 1'b0) begin
      nerr++;
      $display("FAIL raw_wb_same got rdy=%b busy5=%b exp 0 0",
               obs_ready, busy_vector[5]);
    end
    set_wb(0, 0);
    step();
    nvec++;
    if (obs_ready !== 1'b1 || stall_count !== 16'd2) begin
      nerr++;
      $display("FAIL raw_unblock got rdy=%b stall=%0d exp 1 2",
               obs_ready, stall_count);
    end
    idle();
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 3; k++) begin
      set_issue(1, 0, 0, 0, 0, 1, 7);
      step();
    end
    nvec++;
    if (outstanding !== 7'd3 || busy_vector !== model_busy()) begin
      nerr++;
      $display("FAIL sat_three got out=%0d busy=%h exp 3 %h",
               outstanding, busy_vector, model_busy());
    end
    step();
    nvec++;
    if (obs_ready !== 1'b0 || outstanding !== 7'd3) begin
      nerr++;
      $display("FAIL sat_full got rdy=%b out=%0d exp 0 3",
               obs_ready, outstanding);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      set_wb(1, 7);
      step();
    end
    idle();
    nvec++;
    if (outstanding !== 7'd0 || underflow_err !== 1'b0) begin
      nerr++;
      $display("FAIL sat_drain got out=%0d err=%b exp 0 0",
               outstanding, underflow_err);
    end
  endtask

  task automatic test_same_cycle();
    set_issue(1, 0, 0, 0, 0, 1, 9);
    step();
    set_wb(1, 9);
    step();
    nvec++;
    if (obs_ready !== 1'b1 || busy_vector[9] !== 1'b1
        || outstanding !== 7'd1 || underflow_err !== 1'b0) begin
      nerr++;
      $display("FAIL same_cyc got rdy=%b busy9=%b out=%0d err=%b exp 1 1 1 0",
               obs_ready, busy_vector[9], outstanding, underflow_err);
    end
    idle();
    set_wb(1, 9);
    step();
    idle();
  endtask

  task automatic test_flush();
    for (int r = 1; r <= 5; r++) begin
      set_issue(1, 0, 0, 0, 0, 1, r);
      step();
    end
    idle();
    nvec++;
    if (outstanding !== 7'd5) begin
      nerr++;
      $display("FAIL fl_pre got out=%0d exp 5", outstanding);
    end
    flush = 1;
    set_issue(1, 0, 0, 0, 0, 1, 6);
    set_wb(1, 1);
    step();
    nvec++;
    if (outstanding !== 7'd0 || busy_vector !== '0) begin
      nerr++;
      $display("FAIL fl_clear got out=%0d busy=%h exp 0 0",
               outstanding, busy_vector);
    end
    flush = 0;
    set_wb(1, 2);
    step();
    nvec++;
    if (obs_ready !== 1'b0 || underflow_err !== 1'b0
        || outstanding !== 7'd0) begin
      nerr++;
      $display("FAIL fl_state got rdy=%b err=%b out=%0d exp 0 0 0",
               obs_ready, underflow_err, outstanding);
    end
    set_wb(0, 0);
    step();
    nvec++;
    if (obs_ready !== 1'b1 || outstanding !== 7'd1) begin
      nerr++;
      $display("FAIL fl_resume got rdy=%b out=%0d exp 1 1",
               obs_ready, outstanding);
    end
    idle();
    set_wb(1, 6);
    step();
    idle();
  endtask

  task automatic test_underflow_x0();
    set_wb(1, 4);
    step();
    nvec++;
    if (underflow_err !== 1'b1 || outstanding !== 7'd0) begin
      nerr++;
      $display("FAIL uf_set got err=%b out=%0d exp 1 0",
               underflow_err, outstanding);
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      set_issue(1, 1, 0, 1, 0, 1, 0);
      step();
      nvec++;
      if (obs_ready !== 1'b1 || busy_vector[0] !== 1'b0
          || underflow_err !== 1'b1) begin
        nerr++;
        $display("FAIL x0_ready k=%0d got rdy=%b busy0=%b err=%b exp 1 0 1",
                 k, obs_ready, busy_vector[0], underflow_err);
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    set_issue(1, 0, 0, 0, 0, 1, 3);
    step();
    set_issue(1, 0, 0, 0, 0, 1, 4);
    step();
    set_issue(1, 1, 3, 0, 0, 0, 0);
    step();
    nvec++;
    if (outstanding !== 7'd2 || obs_ready !== 1'b0) begin
      nerr++;
      $display("FAIL ar_pre got out=%0d rdy=%b exp 2 0",
               outstanding, obs_ready);
    end
    #2 reset = 1'b1;
    #1;
    nvec++;
    if (outstanding !== '0 || busy_vector !== '0
        || stall_count !== '0 || underflow_err !== 1'b0) begin
      nerr++;
      $display("FAIL ar_async got out=%0d busy=%h stall=%0d err=%b exp 0",
               outstanding, busy_vector, stall_count, underflow_err);
    end
    model_reset();
    @(posedge clock);
    #3 reset = 1'b0;
    step();
    nvec++;
    if (obs_ready !== 1'b1 || stall_count !== '0) begin
      nerr++;
      $display("FAIL ar_release got rdy=%b stall=%0d exp 1 0",
               obs_ready, stall_count);
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_issue($urandom_range(0, 3) != 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), $urandom_range(0, 7),
                1'($urandom_range(0, 1)), $urandom_range(0, 7));
      set_wb($urandom_range(0, 4) < 2, $urandom_range(0, 7));
      flush = ($urandom_range(0, 29) == 0);
      step();
      nvec++;
      if (obs_ready !== exp_ready) begin
        nerr++;
        $display("FAIL rnd_ready c=%0d got=%b exp=%b",
                 c, obs_ready, exp_ready);
      end
      nvec++;
      if (busy_vector !== model_busy()
          || outstanding !== 7'(model_sum())) begin
        nerr++;
        $display("FAIL rnd_state c=%0d got busy=%h out=%0d exp %h %0d",
                 c, busy_vector, outstanding, model_busy(), model_sum());
      end
      nvec++;
      if (stall_count !== 16'(m_stall) || underflow_err !== m_err) begin
        nerr++;
        $display("FAIL rnd_flags c=%0d got stall=%0d err=%b exp %0d %b",
                 c, stall_count, underflow_err, m_stall, m_err);
      end
    end
    idle();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    model_reset();
    test_reset();
    test_raw_stall();
    test_saturate();
    test_same_cycle();
    test_flush();
    test_underflow_x0();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
